// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//   Single-clock FIFO controller with occupancy reporting, programmable
//   almost-full / almost-empty thresholds, sticky overflow / underflow flags
//   and an optional first-word-fall-through read port.
//
// Build option:
//   SYNC_FIFO_FWFT_EN  defined   -> first-word-fall-through read port
//                      undefined -> registered read, latency 1
//
// Parameters:
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  log2 of depth (DEPTH = 2**ADDR_WIDTH)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write request / word
//   rd_en           read request (pop / acknowledge in FWFT mode)
//   rd_data         read word
//   rd_valid        rd_data holds a valid word
//   full, empty     occupancy == DEPTH / == 0 (registered)
//   almost_full     (af_thresh != 0) && level >= af_thresh
//   almost_empty    level <= ae_thresh
//   level           occupancy 0..DEPTH (registered)
//   af_thresh       almost-full threshold, quasi-static
//   ae_thresh       almost-empty threshold, quasi-static
//   overflow        sticky: a write was rejected
//   underflow       sticky: a read was rejected
//   clr_err         clears overflow / underflow (a same-cycle error wins)
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra bit so full and empty stay distinct after wrap.
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0] wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic                wr_acc, rd_acc;

    always_comb begin
        wr_acc     = wr_en && !full;
        rd_acc     = rd_en && !empty;
        wr_ptr_nxt = wr_ptr + (wr_acc ? PTR_ONE : '0);
        rd_ptr_nxt = rd_ptr + (rd_acc ? PTR_ONE : '0);
        // Modular difference of the extended pointers is the true occupancy.
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            full      <= (level_nxt == DEPTH_CNT);
            empty     <= (level_nxt == '0);
            // New error takes priority over a same-cycle clear.
            overflow  <= (wr_en && full)  || (overflow  && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end

    // Storage is not reset; pointer reset alone makes old contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head of queue is presented directly; zeroed while nothing is stored.
    always_comb begin
        rd_valid = !empty;
        rd_data  = empty ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
`else
    // Registered read: word and one-cycle valid pulse follow an accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc)
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end
`endif

    assign almost_full  = (af_thresh != '0) && (level >= af_thresh);
    assign almost_empty = (level <= ae_thresh);

endmodule
